// File: rtl/grf_sched_pkg.sv
// Shared definitions for the GRF write-back scheduler.
//  REG_AW / NREG : register address width and register-file depth
//  grant_t       : which requester owns the GRF write port this cycle
//  grf_wr_t      : one registered GRF write (we, a3, wd, pc)
package grf_sched_pkg;

  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    REQ_P    = 2'd1,
    REQ_L    = 2'd2
  } grant_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] a3;
    logic [31:0]       wd;
    logic [31:0]       pc;
  } grf_wr_t;

endpackage

// File: rtl/grf_scoreboard.sv
// Register ownership scoreboard for long-latency ops.
//  Clk, Reset_n          : clock, async active-low reset
//  iss_valid/rs/rt/dst   : instruction presented by decode
//  iss_long              : instruction writes back through the long unit
//  clr_valid, clr_addr   : long-unit write granted this cycle (releases clr_addr)
//  iss_stall             : decode must hold (RAW/WAW hazard or long unit full)
module grf_scoreboard
  import grf_sched_pkg::*;
#(
  parameter int MAX_LONG = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs,
  input  logic [REG_AW-1:0] iss_rt,
  input  logic [REG_AW-1:0] iss_dst,
  input  logic              iss_long,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_addr,
  output logic              iss_stall
);

  localparam int CW = $clog2(MAX_LONG + 1);

  // $0 is never owed, so only bits 31:1 are stored.
  logic [NREG-1:1] pending_q;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            inc;
  logic            dec;

  assign pending = {pending_q, 1'b0};
  assign full    = (cnt == CW'(MAX_LONG));

  // Uses registered ownership only: a same-cycle L grant does not unstall.
  assign iss_stall = iss_valid & (pending[iss_rs] | pending[iss_rt] | pending[iss_dst] |
                                  (iss_long & (iss_dst != '0) & full));

  assign inc = iss_valid & ~iss_stall & iss_long & (iss_dst != '0);
  assign dec = clr_valid & (clr_addr != '0);

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (inc) set_mask[iss_dst] = 1'b1;
    if (dec) clr_mask[clr_addr] = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_q <= '0;
      cnt       <= '0;
    end else begin
      // Clear applied after set: if both hit one register, the L grant wins.
      pending_q <= (pending_q | set_mask[NREG-1:1]) & ~clr_mask[NREG-1:1];
      case ({inc, dec})
        2'b10:   if (!full) cnt <= cnt + CW'(1);
        2'b01:   if (cnt != '0) cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A release with nothing in flight means the long unit broke protocol.
  assert property (@(posedge Clk) disable iff (!Reset_n) !(dec && !inc && (cnt == '0)));

endmodule

// File: rtl/grf_wb_sched.sv
// Write-back scheduler for the single GRF write port.
//  Clk, Reset_n                 : clock, async active-low reset
//  iss_*  / iss_stall           : decode interface and hazard stall
//  p_valid/addr/data/pc, wb_hold: W-stage write request; hold when L is forced
//  l_valid/addr/data/pc, l_ready: long-unit write request and acceptance
//  grf_we/a3/wd/pc              : registered GRF write port
// P has fixed priority; after MAX_WAIT consecutive losses L is forced through.
module grf_wb_sched
  import grf_sched_pkg::*;
#(
  parameter int MAX_LONG = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rs,
  input  logic [REG_AW-1:0] iss_rt,
  input  logic [REG_AW-1:0] iss_dst,
  input  logic              iss_long,
  output logic              iss_stall,
  input  logic              p_valid,
  input  logic [REG_AW-1:0] p_addr,
  input  logic [31:0]       p_data,
  input  logic [31:0]       p_pc,
  output logic              wb_hold,
  input  logic              l_valid,
  input  logic [REG_AW-1:0] l_addr,
  input  logic [31:0]       l_data,
  input  logic [31:0]       l_pc,
  output logic              l_ready,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_a3,
  output logic [31:0]       grf_wd,
  output logic [31:0]       grf_pc
);

  localparam int WW = $clog2(MAX_WAIT + 2);

  grant_t        grant;
  logic          force_l;
  logic [WW-1:0] wait_cnt;
  grf_wr_t       wr_d;
  grf_wr_t       wr_q;

  always_comb begin
    force_l = l_valid && (wait_cnt == WW'(MAX_WAIT));
    grant   = GNT_NONE;
    if (force_l)      grant = REQ_L;
    else if (p_valid) grant = REQ_P;
    else if (l_valid) grant = REQ_L;
  end

  assign wb_hold = force_l;
  assign l_ready = (grant == REQ_L);

  always_comb begin
    wr_d = '0;
    case (grant)
      REQ_P: begin
        wr_d.we = (p_addr != '0);
        wr_d.a3 = p_addr;
        wr_d.wd = p_data;
        wr_d.pc = p_pc;
      end
      REQ_L: begin
        wr_d.we = (l_addr != '0);
        wr_d.a3 = l_addr;
        wr_d.wd = l_data;
        wr_d.pc = l_pc;
      end
      default: wr_d = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
      wr_q     <= '0;
    end else begin
      // Forced grant bounds wait_cnt at MAX_WAIT, so no saturation needed.
      if (!l_valid || (grant == REQ_L)) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + WW'(1);
      wr_q <= wr_d;
    end
  end

  assign grf_we = wr_q.we;
  assign grf_a3 = wr_q.a3;
  assign grf_wd = wr_q.wd;
  assign grf_pc = wr_q.pc;

  grf_scoreboard #(.MAX_LONG(MAX_LONG)) u_scoreboard (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .iss_valid (iss_valid),
    .iss_rs    (iss_rs),
    .iss_rt    (iss_rt),
    .iss_dst   (iss_dst),
    .iss_long  (iss_long),
    .clr_valid (grant == REQ_L),
    .clr_addr  (l_addr),
    .iss_stall (iss_stall)
  );

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for grf_wb_sched. Stimulus pushes expected GRF writes into
// a queue; a negedge monitor pops one entry per observed grf_we and compares.
module tb_grf_wb_sched;
  import grf_sched_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rs, iss_rt, iss_dst;
  logic        iss_stall;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data, p_pc;
  logic        wb_hold;
  logic        l_valid;
  logic [4:0]  l_addr;
  logic [31:0] l_data, l_pc;
  logic        l_ready;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int n_checks = 0;
  int n_errors = 0;
  grf_wr_t exp_q[$];
  grf_wr_t mon_e;

  always #5 Clk = ~Clk;

  grf_wb_sched #(.MAX_LONG(4), .MAX_WAIT(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_dst(iss_dst),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc), .wb_hold(wb_hold),
    .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_pc(l_pc), .l_ready(l_ready),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic lng);
    iss_valid = v; iss_rs = rs; iss_rt = rt; iss_dst = dst; iss_long = lng;
  endtask

  task automatic set_p(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    p_valid = v; p_addr = a; p_data = d; p_pc = pc;
  endtask

  task automatic set_l(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    l_valid = v; l_addr = a; l_data = d; l_pc = pc;
  endtask

  task automatic idle();
    set_iss(0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0);
    set_l(0, 0, 0, 0);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    grf_wr_t e;
    e.we = 1'b1; e.a3 = a; e.wd = d; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Issue long ops for dst lo..hi, each expected to be accepted.
  task automatic issue_longs(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      set_iss(1, 0, 0, 5'(r), 1);
      #1 check("long_issue_accept", iss_stall, 0);
      cyc();
    end
    set_iss(0, 0, 0, 0, 0);
  endtask

  // Long unit writes back registers lo..hi, one grant per cycle.
  task automatic drain(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      set_l(1, 5'(r), 32'h20 + 32'(r), 32'h600 + 32'(4 * r));
      push(5'(r), 32'h20 + 32'(r), 32'h600 + 32'(4 * r));
      #1 check("drain_l_ready", l_ready, 1);
      cyc();
    end
    set_l(0, 0, 0, 0);
  endtask

  // Monitor: every GRF write must match the oldest expected entry.
  always @(negedge Clk) begin
    if (Reset_n && grf_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h, expected no write", grf_a3, grf_wd, grf_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("grf_write", {grf_a3, grf_wd, grf_pc}, {mon_e.a3, mon_e.wd, mon_e.pc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    idle();
    #12;
    check("reset_we", grf_we, 0);
    check("reset_wd_pc_a3", {grf_a3, grf_wd, grf_pc}, 0);
    #1 Reset_n = 1'b1;
    cyc();

    // RAW stall on a long-op destination until L writes it back.
    set_iss(1, 0, 0, 8, 1);
    #1 check("t2_long_issue", iss_stall, 0);
    cyc();
    set_iss(1, 8, 0, 3, 0);
    #1 check("t2_raw_stall", iss_stall, 1);
    cyc();
    check("t2_raw_stall_hold", iss_stall, 1);
    set_l(1, 8, 32'h1234, 32'h400);
    push(8, 32'h1234, 32'h400);
    #1 check("t2_l_ready", l_ready, 1);
    check("t2_stall_same_cycle_grant", iss_stall, 1);
    cyc();
    set_l(0, 0, 0, 0);
    #1 check("t2_stall_released", iss_stall, 0);
    cyc();
    idle();

    // Starvation guard: P wins three cycles, then L is forced with wb_hold.
    issue_longs(9, 9);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_p(1, 5, 32'hA0 + 32'(i), 32'h1000 + 32'(4 * i));
      set_l(i < 4, 9, 32'hBEEF, 32'h2000);
      #1 check("t3_wb_hold", wb_hold, (i == 3));
      check("t3_l_ready", l_ready, (i == 3));
      if (i == 3) push(9, 32'hBEEF, 32'h2000);
      else        push(5, p_data, p_pc);
      cyc();
    end
    idle();

    // Long-unit capacity: fifth long issue stalls while four are in flight.
    issue_longs(1, 4);
    set_iss(1, 0, 0, 5, 1);
    set_l(1, 1, 32'h11, 32'h500);
    push(1, 32'h11, 32'h500);
    #1 check("t4_full_stall", iss_stall, 1);
    check("t4_l_ready", l_ready, 1);
    cyc();
    set_l(0, 0, 0, 0);
    #1 check("t4_retry_accept", iss_stall, 0);
    cyc();
    set_iss(1, 5, 0, 0, 0);
    #1 check("t4_dst5_pending", iss_stall, 1);
    set_iss(1, 0, 0, 6, 1);
    #1 check("t4_cnt_full", iss_stall, 1);
    set_iss(0, 0, 0, 0, 0);
    drain(2, 4);
    // Issue and release in one cycle: count unchanged at 1.
    set_iss(1, 0, 0, 12, 1);
    set_l(1, 5, 32'h55, 32'h700);
    push(5, 32'h55, 32'h700);
    #1 check("t4_sim_issue", iss_stall, 0);
    check("t4_sim_l_ready", l_ready, 1);
    cyc();
    idle();
    set_iss(1, 5, 0, 0, 0);
    #1 check("t4_dst5_cleared", iss_stall, 0);
    set_iss(1, 12, 0, 0, 0);
    #1 check("t4_dst12_pending", iss_stall, 1);
    set_iss(0, 0, 0, 0, 0);
    issue_longs(13, 15);
    set_iss(1, 0, 0, 16, 1);
    #1 check("t4_cnt_back_to_full", iss_stall, 1);
    set_iss(0, 0, 0, 0, 0);
    drain(12, 15);

    // $0 destinations: long issue and L write to $0 leave count alone.
    set_iss(1, 0, 0, 0, 1);
    set_l(1, 0, 32'hDEAD, 32'h800);
    #1 check("t5_issue_dst0", iss_stall, 0);
    check("t5_l_ready_addr0", l_ready, 1);
    cyc();
    idle();
    #1 check("t5_grf_we_addr0", grf_we, 0);
    issue_longs(13, 16);
    set_iss(1, 0, 0, 17, 1);
    #1 check("t5_cnt_unchanged", iss_stall, 1);
    set_iss(0, 0, 0, 0, 0);
    drain(13, 16);

    // P write to $0 suppresses WE; losing L still accumulates wait.
    set_p(1, 0, 32'h55, 32'h3000);
    set_l(1, 0, 32'h77, 32'h900);
    for (int i = 0; i < 4; i++) begin
      #1 check("t6_l_ready", l_ready, (i == 3));
      check("t6_wb_hold", wb_hold, (i == 3));
      cyc();
      #1 check("t6_grf_we", grf_we, 0);
    end
    idle();
    cyc();

    // Asynchronous reset in the middle of traffic.
    set_iss(1, 0, 0, 10, 1);
    set_p(1, 6, 32'h66, 32'h3100);
    push(6, 32'h66, 32'h3100);
    #1 check("t1_issue", iss_stall, 0);
    cyc();
    idle();
    @(negedge Clk);
    #1 check("t1_write_before_reset", grf_we, 1);
    Reset_n = 1'b0;
    #1 check("t1_reset_we", grf_we, 0);
    check("t1_reset_a3_wd_pc", {grf_a3, grf_wd, grf_pc}, 0);
    #2 Reset_n = 1'b1;
    cyc();
    set_iss(1, 10, 0, 0, 0);
    #1 check("t1_pending_cleared", iss_stall, 0);
    set_iss(0, 0, 0, 0, 0);
    cyc();
    cyc();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
